// File: rtl/mmio_score_bank.sv
// Memory-mapped score/event bank for N players: edge-captured points, per-player event
// queues with overflow, auto-score mode, win detection and game-over lockout.
module mmio_score_bank #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 3,
  parameter int EVT_CNT_W   = 4,
  parameter int ADDR_W      = 12,
  parameter int BASE_ADDR   = 2046,
  parameter int WIN_SCORE   = 7
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic [ADDR_W-1:0]              address,
  input  logic [31:0]                    data,
  input  logic                           wren,
  input  logic [NUM_PLAYERS-1:0]         point,
  output logic                           sel,
  output logic                           hit,
  output logic [31:0]                    rdata,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [2:0]                     winner,
  output logic                           irq
);

  localparam int WIN_WORDS = 4 + 2 * NUM_PLAYERS;

  logic [ADDR_W-1:0]      offset;
  logic [SCORE_W-1:0]     score_r [NUM_PLAYERS];
  logic [EVT_CNT_W-1:0]   count_r [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] ovf;
  logic [NUM_PLAYERS-1:0] point_q;
  logic                   auto_mode;
  logic                   freeze;

  logic                   wr_en;
  logic                   wr_clear;
  logic                   wr_ctrl;
  logic                   restart;
  logic [NUM_PLAYERS-1:0] wr_score;
  logic [NUM_PLAYERS-1:0] pop;
  logic [NUM_PLAYERS-1:0] pt_edge;
  logic [NUM_PLAYERS-1:0] event_bits;
  logic                   win_any;
  logic [2:0]             win_idx;
  logic [31:0]            rd_next;

  assign offset = address - ADDR_W'(BASE_ADDR);
  assign sel    = (address >= ADDR_W'(BASE_ADDR)) && (offset < ADDR_W'(WIN_WORDS));

  // Edges are dropped while frozen, after the game ends, and in a RESTART cycle.
  always_comb begin
    wr_en    = wren & sel;
    wr_clear = wr_en && (offset == ADDR_W'(1));
    wr_ctrl  = wr_en && (offset == ADDR_W'(2));
    restart  = wr_ctrl & data[2];
    wr_score = '0;
    pop      = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      wr_score[i] = wr_en && (offset == ADDR_W'(4 + i));
      pop[i]      = wr_clear & data[i];
    end
    pt_edge = point & ~point_q & {NUM_PLAYERS{~(freeze | game_over | restart)}};
  end

  // Lowest-index player at or above the winning score.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (score_r[i] >= SCORE_W'(WIN_SCORE)) begin
        win_any = 1'b1;
        win_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      point_q   <= '0;
      auto_mode <= 1'b0;
      freeze    <= 1'b0;
      game_over <= 1'b0;
      winner    <= '0;
      ovf       <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_r[i] <= '0;
        count_r[i] <= '0;
      end
    end else begin
      point_q <= point;
      if (restart) begin
        auto_mode <= data[0];
        freeze    <= 1'b0;
        game_over <= 1'b0;
        winner    <= '0;
        ovf       <= '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          score_r[i] <= '0;
          count_r[i] <= '0;
        end
      end else begin
        if (wr_ctrl) begin
          auto_mode <= data[0];
          freeze    <= data[1];
        end
        if (!game_over && win_any) begin
          game_over <= 1'b1;
          winner    <= win_idx;
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (wr_score[i])
            score_r[i] <= data[SCORE_W-1:0];
          else if (auto_mode && pt_edge[i] && (score_r[i] != '1))
            score_r[i] <= score_r[i] + 1'b1;

          // A queued edge and a pop in the same cycle cancel out.
          if (!auto_mode && pt_edge[i] && !pop[i]) begin
            if (count_r[i] == '1)
              ovf[i] <= 1'b1;
            else
              count_r[i] <= count_r[i] + 1'b1;
          end else if (pop[i] && !(!auto_mode && pt_edge[i]) && (count_r[i] != '0)) begin
            count_r[i] <= count_r[i] - 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    if (sel) begin
      if (offset == ADDR_W'(0))
        rd_next[NUM_PLAYERS-1:0] = event_bits;
      if (offset == ADDR_W'(2))
        rd_next[1:0] = {freeze, auto_mode};
      if (offset == ADDR_W'(3)) begin
        rd_next[NUM_PLAYERS-1:0] = ovf;
        rd_next[16]              = game_over;
        rd_next[19:17]           = winner;
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (offset == ADDR_W'(4 + i))
          rd_next[SCORE_W-1:0] = score_r[i];
        if (offset == ADDR_W'(4 + NUM_PLAYERS + i))
          rd_next[EVT_CNT_W-1:0] = count_r[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      hit   <= 1'b0;
      rdata <= '0;
    end else begin
      hit   <= sel;
      rdata <= rd_next;
    end
  end

  always_comb begin
    scores     = '0;
    event_bits = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      scores[i*SCORE_W +: SCORE_W] = score_r[i];
      event_bits[i]                = (count_r[i] != '0);
    end
    irq = |event_bits;
  end

endmodule

// File: tb/tb_mmio_score_bank.sv
// Directed bench for mmio_score_bank with default parameters (N=2, SCORE_W=3, EVT_CNT_W=4).
module tb_mmio_score_bank;

  localparam int BASE = 2046;
  localparam logic [11:0] A_EVENT  = 12'(BASE + 0);
  localparam logic [11:0] A_CLEAR  = 12'(BASE + 1);
  localparam logic [11:0] A_CTRL   = 12'(BASE + 2);
  localparam logic [11:0] A_STATUS = 12'(BASE + 3);
  localparam logic [11:0] A_SCORE0 = 12'(BASE + 4);
  localparam logic [11:0] A_SCORE1 = 12'(BASE + 5);
  localparam logic [11:0] A_COUNT0 = 12'(BASE + 6);
  localparam logic [11:0] A_COUNT1 = 12'(BASE + 7);

  logic        clock = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic [1:0]  point;
  logic        sel;
  logic        hit;
  logic [31:0] rdata;
  logic [5:0]  scores;
  logic        game_over;
  logic [2:0]  winner;
  logic        irq;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  mmio_score_bank dut (
    .clock     (clock),
    .rst       (rst),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .point     (point),
    .sel       (sel),
    .hit       (hit),
    .rdata     (rdata),
    .scores    (scores),
    .game_over (game_over),
    .winner    (winner),
    .irq       (irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    address = a;
    data    = d;
    wren    = 1'b1;
    tick();
    wren    = 1'b0;
  endtask

  task automatic read_check(input logic [11:0] a, input logic [31:0] expected, input string tag);
    address = a;
    wren    = 1'b0;
    tick();
    check_output(tag, rdata, expected);
  endtask

  task automatic pulse(input logic [1:0] p);
    point = p;
    tick();
    point = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1; address = '0; data = '0; wren = 1'b0; point = 2'b00;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and register window
    check_output("reset_scores", 32'(scores), 32'h0);
    check_output("reset_game_over", 32'(game_over), 32'h0);
    check_output("reset_irq", 32'(irq), 32'h0);
    check_output("reset_hit", 32'(hit), 32'h0);
    for (int i = 0; i < 8; i++) begin
      address = 12'(BASE + i);
      tick();
      check_output($sformatf("reset_rdata_off%0d", i), rdata, 32'h0);
      check_output($sformatf("reset_hit_off%0d", i), 32'(hit), 32'h1);
    end
    address = 12'(BASE - 1);
    #1;
    check_output("sel_below_window", 32'(sel), 32'h0);
    tick();
    check_output("hit_below_window", 32'(hit), 32'h0);
    address = 12'(BASE + 8);
    #1;
    check_output("sel_above_window", 32'(sel), 32'h0);

    // Held level counts once, then two pulses, then one pop
    point = 2'b01;
    tick();
    read_check(A_COUNT0, 32'd1, "count0_held_once");
    tick(); tick(); tick();
    point = 2'b00;
    tick();
    pulse(2'b01);
    pulse(2'b01);
    read_check(A_COUNT0, 32'd3, "count0_after_pulses");
    read_check(A_EVENT, 32'h1, "event_player0");
    check_output("irq_pending", 32'(irq), 32'h1);
    bus_write(A_CLEAR, 32'h1);
    read_check(A_COUNT0, 32'd2, "count0_after_clear");

    // Edge and pop in the same cycle cancel
    pulse(2'b10);
    read_check(A_COUNT1, 32'd1, "count1_one_edge");
    point = 2'b10;
    bus_write(A_CLEAR, 32'h2);
    point = 2'b00;
    tick();
    read_check(A_COUNT1, 32'd1, "count1_edge_and_pop");

    // Overflow: 1 + 16 edges saturates at 15 and sets sticky flag
    for (int i = 0; i < 16; i++) pulse(2'b10);
    read_check(A_COUNT1, 32'd15, "count1_saturated");
    read_check(A_STATUS, 32'h2, "status_overflow1");
    bus_write(A_CTRL, 32'h4);
    read_check(A_COUNT1, 32'd0, "count1_after_restart");
    read_check(A_COUNT0, 32'd0, "count0_after_restart");
    read_check(A_STATUS, 32'h0, "status_after_restart");
    check_output("irq_after_restart", 32'(irq), 32'h0);

    // Auto mode: seven edges on player 1 reach the winning score
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) pulse(2'b10);
    check_output("score1_six", 32'(scores[5:3]), 32'd6);
    point = 2'b10;
    tick();
    check_output("score1_seven", 32'(scores[5:3]), 32'd7);
    check_output("game_over_not_yet", 32'(game_over), 32'h0);
    point = 2'b00;
    tick();
    check_output("game_over_set", 32'(game_over), 32'h1);
    check_output("winner_is_1", 32'(winner), 32'd1);
    read_check(A_STATUS, 32'h0003_0000, "status_win");
    read_check(A_COUNT1, 32'd0, "count1_untouched_auto");
    pulse(2'b10);
    check_output("score1_locked", 32'(scores[5:3]), 32'd7);
    check_output("score0_zero", 32'(scores[2:0]), 32'd0);

    // Restart keeping AUTO, then bus write wins over same-cycle edge
    bus_write(A_CTRL, 32'h5);
    check_output("scores_after_restart_auto", 32'(scores), 32'h0);
    check_output("game_over_cleared", 32'(game_over), 32'h0);
    read_check(A_CTRL, 32'h1, "ctrl_auto_kept");
    bus_write(A_SCORE0, 32'd3);
    point = 2'b01;
    bus_write(A_SCORE0, 32'd5);
    point = 2'b00;
    check_output("read_before_write", rdata, 32'd3);
    check_output("score0_write_wins", 32'(scores[2:0]), 32'd5);
    tick();
    pulse(2'b01);
    check_output("score0_auto_inc", 32'(scores[2:0]), 32'd6);
    bus_write(A_SCORE0, 32'hFFFF_FFF7);
    check_output("score0_upper_ignored", 32'(scores[2:0]), 32'd7);
    check_output("game_over_lag", 32'(game_over), 32'h0);
    tick();
    check_output("game_over_by_write", 32'(game_over), 32'h1);
    check_output("winner_is_0", 32'(winner), 32'd0);

    // Freeze discards edges; restart with AUTO clears freeze
    bus_write(A_CTRL, 32'h4);
    bus_write(A_CTRL, 32'h2);
    pulse(2'b11);
    read_check(A_COUNT0, 32'd0, "count0_frozen");
    read_check(A_COUNT1, 32'd0, "count1_frozen");
    bus_write(A_SCORE1, 32'd3);
    check_output("score1_write_frozen", 32'(scores[5:3]), 32'd3);
    bus_write(A_CTRL, 32'h5);
    check_output("scores_cleared_final", 32'(scores), 32'h0);
    read_check(A_CTRL, 32'h1, "ctrl_freeze_cleared");
    pulse(2'b01);
    check_output("score0_unfrozen_inc", 32'(scores[2:0]), 32'd1);
    read_check(A_COUNT0, 32'd0, "count0_auto_untouched");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
